fp_norm_round: RTL and testbench
================================

FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 The module SHALL have parameter N, default 32, giving the IEEE-754 word width; only 32 and 64 are legal.
REQ-002 The module SHALL derive EXP_LEN as 8 for N=32 and 11 for N=64, and MAN as 23 for N=32 and 52 for N=64.
REQ-003 clk  input  1  the single clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  the upstream adder presents a raw sum.
REQ-006 in_ready  output  1  the block accepts the raw sum this cycle.
REQ-007 in_sign  input  1  sign of the raw sum.
REQ-008 in_exp  input  EXP_LEN  biased exponent of the larger operand.
REQ-009 in_mant  input  MAN+5  packed mantissa, MSB to LSB:
- [MAN+4] carry
- [MAN+3] hidden
- [MAN+2:3] fraction
- [2] guard, [1] round, [0] sticky
REQ-010 in_nan, in_inf  input  1 each  special-operand flags from upstream.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out  output  N  packed IEEE result.
REQ-014 out_ovf, out_unf, out_inx  output  1 each  overflow, underflow and inexact flags, aligned with out.

Function
REQ-015 The block SHALL be a two-stage valid/ready pipeline: S1 normalises, S2 rounds and packs.
REQ-016 Latency SHALL be 2 cycles from input handshake to out_valid, and throughput SHALL be one result per cycle with no stall.
REQ-017 Each stage SHALL load when it is empty or its content is leaving in the same cycle, and in_ready SHALL equal !s1_valid | s1_advance.
REQ-018 Results SHALL leave in input order and SHALL never be lost or duplicated under backpressure.
REQ-019 When out_valid=1 and out_ready=0, out and its flags SHALL stay stable.
REQ-020 S1 carry case: if carry=1, the mantissa SHALL shift right one place, the shifted-out bit SHALL be ORed into sticky, and the exponent SHALL increase by 1.
REQ-021 S1 left shift: otherwise S1 SHALL left-shift by the leading-zero count of [MAN+3:3], capped so the exponent does not fall below 1.
REQ-022 S1 subnormal: if the cap limits the shift, the stored exponent SHALL be 0 (subnormal result).
REQ-023 S1 zero: a mantissa of all zeros SHALL produce signed zero with sign in_sign and all flags 0.
REQ-024 S2 SHALL round to nearest-even: increment = guard & (round | sticky | lsb).
REQ-025 A round-up carry out of the fraction SHALL increment the exponent and clear the fraction; a subnormal rounding up to the minimum normal SHALL get exponent 1.
REQ-026 An exponent of all-ones or above after any adjustment SHALL give signed infinity with out_ovf=1 and out_inx=1.
REQ-027 out_inx SHALL be guard|round|sticky after normalisation; out_unf SHALL be out_inx & (the result is subnormal or zero).
REQ-028 in_nan=1 SHALL give the canonical quiet NaN (0x7FC00000 for N=32) with all flags 0; in_nan has priority over in_inf.
REQ-029 in_inf=1 SHALL give signed infinity with all flags 0.
REQ-030 Special flags SHALL bypass the arithmetic but follow the same pipeline timing.

Reset
REQ-031 While rst=1 at a clock edge, both stage valids SHALL clear, and out, out_ovf, out_unf and out_inx SHALL reset to 0.
REQ-032 Operations in flight at reset SHALL be discarded.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 Carry normalisation: exp=127, mant carry=1 only, out_ready=1 -> out=0x40000000, flags 0, two cycles later.
REQ-035 Tie to even: exp=127, hidden=1, guard=1, rest 0 -> 0x3F800000 with inx=1; same input with fraction LSB=1 -> 0x3F800002.
REQ-036 Massive cancellation: exp=127, hidden=0, only fraction LSB set -> 0x34000000; all-zero mantissa, sign 1 -> 0x80000000.
REQ-037 Overflow: exp=254, carry=1 -> 0x7F800000 with ovf=1, inx=1.
REQ-038 Backpressure: 5 back-to-back inputs with out_ready=0 for 4 cycles -> in_ready falls after 2 accepted, all 5 outputs are emitted in order, and out holds stable while stalled.
REQ-039 Reset mid-stream: rst pulsed with 2 operations in flight -> out_valid=0 next cycle, no stale result ever appears, in_ready=1 after reset.

Source files
------------

// File: rtl/fp_norm_round.sv
// fp_norm_round: two-stage normalise/round/pack pipeline for raw IEEE-754 adder sums
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid / in_ready       upstream handshake for the raw sum
//   in_sign, in_exp, in_mant  raw sum; in_mant is {carry, hidden, fraction, guard, round, sticky}
//   in_nan, in_inf            special-operand flags (NaN wins over infinity)
//   out_valid / out_ready     downstream handshake
//   out                       packed IEEE result
//   out_ovf, out_unf, out_inx overflow, underflow and inexact flags aligned with out
module fp_norm_round #(
    parameter int N = 32,
    localparam int EXP_LEN = (N == 64) ? 11 : 8,
    localparam int MAN = (N == 64) ? 52 : 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic [EXP_LEN-1:0] in_exp,
    input  logic [MAN+4:0]     in_mant,
    input  logic               in_nan,
    input  logic               in_inf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out,
    output logic               out_ovf,
    output logic               out_unf,
    output logic               out_inx
);
    localparam int EW = EXP_LEN + 1;
    localparam logic [EXP_LEN-1:0] EXP_MAX = '1;

    logic               s1_valid, s1_sign, s1_nan, s1_inf;
    logic [EW-1:0]      s1_exp;
    logic [MAN+3:0]     s1_mant;
    logic               s2_load, s1_advance;
    logic [EW-1:0]      lz, lim, n1_exp, e2;
    logic               limited, grs, inc, ovf, special;
    logic [MAN+3:0]     n1_mant;
    logic [MAN+1:0]     sig;
    logic [N-1:0]       r_out;

    assign s2_load = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready = !s1_valid || s1_advance;

    // leading-zero count over hidden+fraction; the highest set bit wins
    always_comb begin
        lz = EW'(MAN + 1);
        for (int i = 0; i <= MAN; i++)
            if (in_mant[3+i]) lz = EW'(MAN - i);
    end

    // the shift may only bring the exponent down to 1; beyond that the result is subnormal
    assign lim = (in_exp == '0) ? '0 : EW'(in_exp) - 1'b1;
    assign limited = lz > lim;
    assign n1_mant = in_mant[MAN+4] ? {in_mant[MAN+4:2], |in_mant[1:0]}
                                    : in_mant[MAN+3:0] << (limited ? lim : lz);
    assign n1_exp = (in_mant == '0) ? '0
                  : in_mant[MAN+4] ? EW'(in_exp) + 1'b1
                  : limited ? '0 : EW'(in_exp) - lz;

    assign grs = |s1_mant[2:0];
    assign inc = s1_mant[2] && (s1_mant[1] || s1_mant[0] || s1_mant[3]);
    assign sig = {1'b0, s1_mant[MAN+3:3]} + (MAN+2)'(inc);
    // carry out of the significand bumps the exponent; a subnormal reaching the hidden bit becomes exponent 1
    assign e2 = s1_exp + EW'(sig[MAN+1]) + EW'(s1_exp == '0 && sig[MAN]);
    assign ovf = e2 >= EW'(EXP_MAX);
    assign special = s1_nan || s1_inf;
    assign r_out = s1_nan ? {1'b0, EXP_MAX, 1'b1, {(MAN-1){1'b0}}}
                 : (s1_inf || ovf) ? {s1_sign, EXP_MAX, {MAN{1'b0}}}
                 : {s1_sign, e2[EXP_LEN-1:0], sig[MAN-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            out_valid <= 1'b0;
            out <= '0;
            out_ovf <= 1'b0;
            out_unf <= 1'b0;
            out_inx <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                s1_sign <= in_sign;
                s1_exp <= n1_exp;
                s1_mant <= n1_mant;
                s1_nan <= in_nan;
                s1_inf <= in_inf;
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out <= r_out;
                    out_ovf <= !special && ovf;
                    out_inx <= !special && (ovf || grs);
                    out_unf <= !special && grs && e2 == '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round: randomized and directed checks of fp_norm_round against a value-level model
module tb_fp_norm_round;
    typedef struct packed {
        logic [31:0] o;
        logic        ovf;
        logic        unf;
        logic        inx;
    } res_t;

    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, in_sign = 0, in_nan = 0, in_inf = 0;
    logic [7:0]  in_exp = 0;
    logic [27:0] in_mant = 0;
    logic        out_valid, out_ready, out_ovf, out_unf, out_inx;
    logic [31:0] out;
    logic        man_ready = 0, rnd_bit = 1, rnd_mode = 0;
    int          n_cmp = 0, n_err = 0, acc = 0;
    res_t        exp_q[$];
    logic        stalled = 0;
    logic [34:0] held;

    assign out_ready = rnd_mode ? rnd_bit : man_ready;

    fp_norm_round #(.N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_nan(in_nan), .in_inf(in_inf), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .out_ovf(out_ovf),
        .out_unf(out_unf), .out_inx(out_inx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom % 10) < 7;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // value-level reference: normalise as a fixed-point number, then round to nearest even
    function automatic res_t model(logic s, logic [7:0] e, logic [27:0] m, logic nan, logic inf);
        res_t r;
        int ee, lz, lim, sh, rem;
        logic [26:0] mm;
        longint sig;
        r = '0;
        if (nan) begin
            r.o = 32'h7FC00000;
            return r;
        end
        if (inf) begin
            r.o = {s, 8'hFF, 23'h0};
            return r;
        end
        if (m == 0) begin
            r.o = {s, 31'h0};
            return r;
        end
        ee = int'(e);
        if (m[27]) begin
            mm = {m[27:2], m[1] | m[0]};
            ee++;
        end else begin
            lz = 0;
            while (lz < 24 && !m[26-lz]) lz++;
            lim = (ee > 0) ? ee - 1 : 0;
            sh = (lz < lim) ? lz : lim;
            mm = m[26:0] << sh;
            ee = (lz > lim) ? 0 : ee - sh;
        end
        sig = longint'(mm[26:3]);
        rem = int'(mm[2:0]);
        r.inx = rem != 0;
        if (rem > 4 || (rem == 4 && sig[0])) sig++;
        if (sig >= 64'd16777216) begin
            sig = sig >> 1;
            ee++;
        end
        if (ee == 0 && sig >= 64'd8388608) ee = 1;
        if (ee >= 255) begin
            r.o = {s, 8'hFF, 23'h0};
            r.ovf = 1;
            r.inx = 1;
            return r;
        end
        r.o = {s, 8'(ee), 23'(sig)};
        r.unf = r.inx && ee == 0;
        return r;
    endfunction

    // monitor/scoreboard: inputs recorded on acceptance, results checked on every output handshake
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stalled = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_sign, in_exp, in_mant, in_nan, in_inf));
                acc++;
            end
            if (stalled) chk("stall_hold", {29'h0, out, out_ovf, out_unf, out_inx}, {29'h0, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_output: got %h expected none", out);
                end else begin
                    chk("result", {29'h0, out, out_ovf, out_unf, out_inx}, {29'h0, exp_q.pop_front()});
                end
            end
            stalled = out_valid && !out_ready;
            held = {out, out_ovf, out_unf, out_inx};
        end
    end

    task automatic send(logic s, logic [7:0] e, logic [27:0] m, logic nan, logic inf);
        bit ok = 0;
        in_valid = 1;
        in_sign = s;
        in_exp = e;
        in_mant = m;
        in_nan = nan;
        in_inf = inf;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic idle(int n);
        in_valid = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dir(string name, logic s, logic [7:0] e, logic [27:0] m, logic nan, logic inf, res_t req);
        chk(name, {29'h0, model(s, e, m, nan, inf)}, {29'h0, req});
        send(s, e, m, nan, inf);
    endtask

    initial begin
        int a0;
        logic [27:0] m;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", {29'h0, out, out_ovf, out_unf, out_inx}, 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;
        man_ready = 1;

        dir("carry", 0, 127, 28'h8000000, 0, 0, {32'h40000000, 3'b000});
        dir("tie_even", 0, 127, 28'h4000004, 0, 0, {32'h3F800000, 3'b001});
        dir("tie_odd", 0, 127, 28'h400000C, 0, 0, {32'h3F800002, 3'b001});
        dir("cancel", 0, 127, 28'h0000008, 0, 0, {32'h34000000, 3'b000});
        dir("neg_zero", 1, 127, 28'h0, 0, 0, {32'h80000000, 3'b000});
        dir("overflow", 0, 254, 28'h8000000, 0, 0, {32'h7F800000, 3'b101});
        dir("subnormal", 0, 1, 28'h2000000, 0, 0, {32'h00400000, 3'b000});
        dir("sub_to_min", 0, 1, 28'h3FFFFFE, 0, 0, {32'h00800000, 3'b001});
        dir("sub_inexact", 0, 1, 28'h2000001, 0, 0, {32'h00400000, 3'b011});
        dir("nan_prio", 1, 3, 28'h1234567, 1, 1, {32'h7FC00000, 3'b000});
        dir("neg_inf", 1, 3, 28'h1234567, 0, 1, {32'hFF800000, 3'b000});
        idle(6);

        a0 = acc;
        fork
            begin
                send(0, 100, 28'h4000000, 0, 0);
                send(1, 101, 28'h4000008, 0, 0);
                send(0, 102, 28'h8000003, 0, 0);
                send(0, 103, 28'h0000100, 0, 0);
                send(1, 104, 28'h4000006, 0, 0);
                in_valid = 0;
            end
            begin
                man_ready = 0;
                repeat (4) @(posedge clk);
                #2;
                chk("bp_accepted", acc - a0, 2);
                chk("bp_in_ready", in_ready, 0);
                man_ready = 1;
            end
        join
        idle(6);
        chk("bp_all_out", exp_q.size(), 0);

        man_ready = 0;
        send(0, 120, 28'h4000000, 0, 0);
        send(0, 121, 28'h4000000, 0, 0);
        in_valid = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        man_ready = 1;
        idle(5);

        rnd_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 4 == 0) idle(1);
            m = 28'($urandom);
            m[27] = ($urandom % 4 == 0);
            if (!m[27] && $urandom % 2 == 0) m = m >> $urandom_range(27, 1);
            send(1'($urandom), 8'($urandom), m, $urandom % 20 == 0, $urandom % 20 == 0);
        end
        in_valid = 0;
        rnd_mode = 0;
        man_ready = 1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
